// File: rtl/planificador_pisos.sv
// planificador_pisos
// Elevator request scheduler. Latches floor-button calls into a pending
// register, picks the travel direction with a SCAN (collector) policy,
// issues move/stop orders to the motion FSM and holds the door open for
// T_PUERTA cycles at every served floor.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   piso          in   current floor from the motion FSM (valid with llegada)
//   boton         in   level-sensitive call buttons, bit i = floor i
//   llegada       in   one-cycle pulse: car settled at floor piso
//   orden         out  00 PARAR, 01 SUBIR, 10 BAJAR (11 never driven)
//   abrir_puerta  out  high for exactly T_PUERTA cycles per stop
//   pendientes    out  pending-request register
//   direccion     out  current/last sweep direction, 1 up, 0 down
//   estado        out  FSM state: 00 REPOSO, 01 SUBIENDO, 10 BAJANDO, 11 PUERTA
//
// Interface: llegada is a plain strobe with no handshake; it is consumed
// only in SUBIENDO/BAJANDO and ignored in REPOSO and PUERTA. Every output
// comes from registered state, so nothing here feeds inputs straight back.
module planificador_pisos #(
  parameter int N_PISOS  = 4,
  parameter int W_PISO   = 2,
  parameter int T_PUERTA = 100,
  parameter int W_CNT    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W_PISO-1:0]  piso,
  input  logic [N_PISOS-1:0] boton,
  input  logic               llegada,
  output logic [1:0]         orden,
  output logic               abrir_puerta,
  output logic [N_PISOS-1:0] pendientes,
  output logic               direccion,
  output logic [1:0]         estado
);

  localparam logic [1:0] REPOSO   = 2'b00;
  localparam logic [1:0] SUBIENDO = 2'b01;
  localparam logic [1:0] BAJANDO  = 2'b10;
  localparam logic [1:0] PUERTA   = 2'b11;

  localparam logic [W_CNT-1:0] C_FIN = W_CNT'(T_PUERTA - 1);

  logic [1:0]         r_estado;
  logic [1:0]         w_estado_sig;
  logic               r_dir;
  logic               w_dir_sig;
  logic [N_PISOS-1:0] r_pend;
  logic [N_PISOS-1:0] w_clr;
  logic [W_CNT-1:0]   r_cnt;
  logic [W_CNT-1:0]   w_cnt_sig;
  logic               w_arriba;
  logic               w_abajo;
  logic               w_aqui;

  // Requests above/below/at the current floor. An out-of-range piso matches
  // no index, so it yields aqui=0 and no clear.
  always_comb begin
    w_arriba = 1'b0;
    w_abajo  = 1'b0;
    w_aqui   = 1'b0;
    w_clr    = '0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (W_PISO'(i) > piso) w_arriba = w_arriba | r_pend[i];
      if (W_PISO'(i) < piso) w_abajo  = w_abajo  | r_pend[i];
      if (W_PISO'(i) == piso) begin
        w_aqui   = r_pend[i];
        // While the door is open the served floor is cleared every cycle,
        // so a press of the current floor's button is absorbed.
        w_clr[i] = (r_estado == PUERTA);
      end
    end
  end

  always_comb begin
    w_estado_sig = r_estado;
    w_dir_sig    = r_dir;
    w_cnt_sig    = r_cnt;
    case (r_estado)
      REPOSO: begin
        if (w_aqui) begin
          w_estado_sig = PUERTA;
          w_cnt_sig    = '0;
        end else if (w_arriba && w_abajo) begin
          // Calls on both sides: keep sweeping the way we last went.
          w_estado_sig = r_dir ? SUBIENDO : BAJANDO;
        end else if (w_arriba) begin
          w_estado_sig = SUBIENDO;
          w_dir_sig    = 1'b1;
        end else if (w_abajo) begin
          w_estado_sig = BAJANDO;
          w_dir_sig    = 1'b0;
        end
      end
      SUBIENDO: begin
        if (llegada) begin
          if (w_aqui) begin
            w_estado_sig = PUERTA;
            w_cnt_sig    = '0;
          end else if (!w_arriba) begin
            w_estado_sig = REPOSO;
          end
        end
      end
      BAJANDO: begin
        if (llegada) begin
          if (w_aqui) begin
            w_estado_sig = PUERTA;
            w_cnt_sig    = '0;
          end else if (!w_abajo) begin
            w_estado_sig = REPOSO;
          end
        end
      end
      PUERTA: begin
        if (r_cnt == C_FIN) begin
          if (r_dir && w_arriba) begin
            w_estado_sig = SUBIENDO;
          end else if (!r_dir && w_abajo) begin
            w_estado_sig = BAJANDO;
          end else if (w_arriba) begin
            w_estado_sig = SUBIENDO;
            w_dir_sig    = 1'b1;
          end else if (w_abajo) begin
            w_estado_sig = BAJANDO;
            w_dir_sig    = 1'b0;
          end else begin
            w_estado_sig = REPOSO;
          end
        end else begin
          w_cnt_sig = r_cnt + 1'b1;
        end
      end
      default: w_estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= REPOSO;
      r_dir    <= 1'b1;
      r_pend   <= '0;
      r_cnt    <= '0;
    end else begin
      r_estado <= w_estado_sig;
      r_dir    <= w_dir_sig;
      r_pend   <= (r_pend | boton) & ~w_clr;
      r_cnt    <= w_cnt_sig;
    end
  end

  assign orden        = (r_estado == SUBIENDO) ? 2'b01 :
                        (r_estado == BAJANDO)  ? 2'b10 : 2'b00;
  assign abrir_puerta = (r_estado == PUERTA);
  assign pendientes   = r_pend;
  assign direccion    = r_dir;
  assign estado       = r_estado;

endmodule

// File: tb/tb_planificador_pisos.sv
module tb_planificador_pisos;

  logic       clk;
  logic       rst_n;
  logic [1:0] piso;
  logic [3:0] boton;
  logic       llegada;
  logic [1:0] orden;
  logic       abrir_puerta;
  logic [3:0] pendientes;
  logic       direccion;
  logic [1:0] estado;

  int checks = 0;
  int errors = 0;

  planificador_pisos #(
    .N_PISOS(4), .W_PISO(2), .T_PUERTA(100), .W_CNT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .piso(piso),
    .boton(boton),
    .llegada(llegada),
    .orden(orden),
    .abrir_puerta(abrir_puerta),
    .pendientes(pendientes),
    .direccion(direccion),
    .estado(estado)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts cycles with the door open (bounded), counts cycles after the
  // first one where the served floor still shows pending, and optionally
  // pulses llegada at door cycle lleg_at.
  task automatic wait_door(input int idx, input int lleg_at, output int n, output int bad);
    n   = 0;
    bad = 0;
    while (abrir_puerta && n < 300) begin
      if (n > 0 && pendientes[idx]) bad++;
      if (n == lleg_at) llegada = 1'b1;
      tick();
      llegada = 1'b0;
      n++;
    end
  endtask

  int n;
  int bad;

  initial begin
    rst_n   = 1'b0;
    piso    = 2'd0;
    boton   = 4'b0000;
    llegada = 1'b0;
    tick();
    tick();
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_orden", 32'(orden), 32'd0);
    chk("rst_abrir", 32'(abrir_puerta), 32'd0);
    chk("rst_pend", 32'(pendientes), 32'd0);
    chk("rst_dir", 32'(direccion), 32'd1);
    rst_n = 1'b1;
    tick();

    // 1: single call above, intermediate arrival, stop, back to idle
    piso  = 2'd0;
    boton = 4'b0100;
    tick();
    boton = 4'b0000;
    chk("t1_latch_pend", 32'(pendientes), 32'b0100);
    chk("t1_latch_estado", 32'(estado), 32'd0);
    tick();
    chk("t1_subiendo", 32'(estado), 32'd1);
    chk("t1_orden_subir", 32'(orden), 32'd1);
    chk("t1_dir", 32'(direccion), 32'd1);
    piso = 2'd1; llegada = 1'b1;
    tick();
    llegada = 1'b0;
    chk("t1_pass_floor1", 32'(estado), 32'd1);
    piso = 2'd2; llegada = 1'b1;
    tick();
    llegada = 1'b0;
    chk("t1_puerta", 32'(estado), 32'd3);
    chk("t1_abrir", 32'(abrir_puerta), 32'd1);
    chk("t1_orden_parar", 32'(orden), 32'd0);
    wait_door(2, -1, n, bad);
    chk("t1_door_len", 32'(n), 32'd100);
    chk("t1_door_clear", 32'(bad), 32'd0);
    chk("t1_idle", 32'(estado), 32'd0);
    chk("t1_idle_orden", 32'(orden), 32'd0);
    chk("t1_idle_pend", 32'(pendientes), 32'd0);

    // 2: calls at 0 and 3 from floor 1, serve 3 then sweep down to 0
    piso  = 2'd1;
    boton = 4'b1001;
    tick();
    boton = 4'b0000;
    chk("t2_pend", 32'(pendientes), 32'b1001);
    tick();
    chk("t2_subiendo", 32'(estado), 32'd1);
    chk("t2_dir_up", 32'(direccion), 32'd1);
    piso = 2'd3; llegada = 1'b1;
    tick();
    llegada = 1'b0;
    chk("t2_puerta3", 32'(estado), 32'd3);
    wait_door(3, -1, n, bad);
    chk("t2_door3_len", 32'(n), 32'd100);
    chk("t2_door3_clear", 32'(bad), 32'd0);
    chk("t2_bajando", 32'(estado), 32'd2);
    chk("t2_orden_bajar", 32'(orden), 32'd2);
    chk("t2_dir_down", 32'(direccion), 32'd0);
    chk("t2_pend_left", 32'(pendientes), 32'b0001);
    piso = 2'd0; llegada = 1'b1;
    tick();
    llegada = 1'b0;
    chk("t2_puerta0", 32'(estado), 32'd3);
    wait_door(0, -1, n, bad);
    chk("t2_door0_len", 32'(n), 32'd100);
    chk("t2_idle", 32'(estado), 32'd0);
    chk("t2_idle_pend", 32'(pendientes), 32'd0);
    chk("t2_idle_dir", 32'(direccion), 32'd0);

    // 3: tie at floor 2 with last direction down keeps going down
    piso  = 2'd2;
    boton = 4'b1001;
    tick();
    boton = 4'b0000;
    chk("t3_pend", 32'(pendientes), 32'b1001);
    tick();
    chk("t3_bajando", 32'(estado), 32'd2);
    chk("t3_dir", 32'(direccion), 32'd0);
    chk("t3_orden", 32'(orden), 32'd2);
    piso = 2'd1; llegada = 1'b1;
    tick();
    llegada = 1'b0;
    chk("t3_pass_floor1", 32'(estado), 32'd2);

    // 5: reset in the middle of a door interval with 1100 pending
    piso = 2'd0; llegada = 1'b1;
    tick();
    llegada = 1'b0;
    chk("t5_puerta", 32'(estado), 32'd3);
    boton = 4'b0100;
    tick();
    boton = 4'b0000;
    tick();
    tick();
    chk("t5_pend_before", 32'(pendientes), 32'b1100);
    chk("t5_dir_before", 32'(direccion), 32'd0);
    chk("t5_abrir_before", 32'(abrir_puerta), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_abrir", 32'(abrir_puerta), 32'd0);
    chk("t5_estado", 32'(estado), 32'd0);
    chk("t5_pend", 32'(pendientes), 32'd0);
    chk("t5_dir", 32'(direccion), 32'd1);
    chk("t5_orden", 32'(orden), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 4: call at the current floor, button held through the door
    piso  = 2'd1;
    boton = 4'b0010;
    tick();
    chk("t4_pend", 32'(pendientes), 32'b0010);
    chk("t4_estado_idle", 32'(estado), 32'd0);
    tick();
    chk("t4_puerta", 32'(estado), 32'd3);
    chk("t4_orden", 32'(orden), 32'd0);
    wait_door(1, -1, n, bad);
    boton = 4'b0000;
    chk("t4_door_len", 32'(n), 32'd100);
    chk("t4_absorbed", 32'(bad), 32'd0);
    chk("t4_idle", 32'(estado), 32'd0);
    tick();
    chk("t4_pend_after", 32'(pendientes), 32'd0);
    chk("t4_still_idle", 32'(estado), 32'd0);

    // 6: llegada ignored in REPOSO and in PUERTA
    llegada = 1'b1;
    tick();
    llegada = 1'b0;
    chk("t6_idle_lleg", 32'(estado), 32'd0);
    chk("t6_idle_abrir", 32'(abrir_puerta), 32'd0);
    boton = 4'b0010;
    tick();
    boton = 4'b0000;
    tick();
    chk("t6_puerta", 32'(estado), 32'd3);
    wait_door(1, 50, n, bad);
    chk("t6_door_len", 32'(n), 32'd100);
    chk("t6_idle", 32'(estado), 32'd0);

    // top floor: a call at floor 3 while there opens the door, never SUBIR
    piso  = 2'd3;
    boton = 4'b1000;
    tick();
    boton = 4'b0000;
    tick();
    chk("top_puerta", 32'(estado), 32'd3);
    chk("top_orden", 32'(orden), 32'd0);
    wait_door(3, -1, n, bad);
    chk("top_door_len", 32'(n), 32'd100);
    chk("top_idle", 32'(estado), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
